// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: opcodes, FSM states, bus indices and instruction field helpers for bus_sequencer.
package bus_seq_pkg;
  localparam int OP_MV = 0;
  localparam int OP_MVI = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_BZ = 4;
  localparam int TRI_G = 8;
  localparam int TRI_DIN = 9;
`ifdef BUS_SEQ_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {IDLE, T1, T2, T3, TRAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, T1, T2, T3} state_t;
`endif
  function automatic logic [31:0] f_op(logic [31:0] ir, int rw);
    return ir >> (2 * rw);
  endfunction
  function automatic logic [31:0] f_x(logic [31:0] ir, int rw);
    return (ir >> rw) & ((32'd1 << rw) - 32'd1);
  endfunction
  function automatic logic [31:0] f_y(logic [31:0] ir, int rw);
    return ir & ((32'd1 << rw) - 32'd1);
  endfunction
endpackage

// File: rtl/bus_sequencer_reg_dec.sv
// reg_dec: register index to one-hot decoder.
module reg_dec #(
  parameter int RW = 3
) (
  input  logic [RW-1:0]    idx,
  output logic [2**RW-1:0] onehot
);
  assign onehot = (2**RW)'(1) << idx;
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: T1-T3 control FSM for the shared-bus register datapath.
// Optional BUS_SEQ_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP until reset.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int OPW = 3,
  parameter int RW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [OPW+2*RW-1:0]   instruction,
  input  logic                  zero_flag,
  output logic [2**RW+1:0]      tri_en,
  output logic [2**RW-1:0]      reg_en,
  output logic                  a_en,
  output logic                  g_en,
  output logic                  alu_sub,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal
);
  localparam int NREG = 2**RW;
  localparam int IW = OPW + 2 * RW;
`ifdef BUS_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t state;
  logic [IW-1:0] ir;
  logic [OPW-1:0] op;
  logic [RW-1:0] x, y;
  logic [NREG-1:0] xd, yd;
  logic t1, t2, t3, mv, mvi, ar, bz, ill, bz_take;
  assign op = OPW'(f_op(32'(ir), RW));
  assign x = RW'(f_x(32'(ir), RW));
  assign y = RW'(f_y(32'(ir), RW));
  reg_dec #(.RW(RW)) u_dec_x (.idx(x), .onehot(xd));
  reg_dec #(.RW(RW)) u_dec_y (.idx(y), .onehot(yd));
  assign t1 = state == T1;
  assign t2 = state == T2;
  assign t3 = state == T3;
  assign mv = op == OPW'(OP_MV);
  assign mvi = op == OPW'(OP_MVI);
  assign ar = op == OPW'(OP_ADD) || op == OPW'(OP_SUB);
  assign bz = op == OPW'(OP_BZ);
  assign ill = !(mv || mvi || ar || bz);
  assign bz_take = bz && zero_flag;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ir <= '0;
    end else
      case (state)
        IDLE: if (run) begin
          ir <= instruction;
          state <= T1;
        end
`ifdef BUS_SEQ_ILLEGAL_TRAP_EN
        T1: state <= ar ? T2 : ill ? TRAP : IDLE;
`else
        T1: state <= ar ? T2 : IDLE;
`endif
        T2: state <= T3;
        T3: state <= IDLE;
        default: state <= state;
      endcase
  // reg_en stays low until T3 for add/sub, so a reset mid-ALU-op leaves registers intact
  assign tri_en = (t1 && (mv || bz_take)) || t2 ? {2'b00, yd} :
                  t1 && ar ? {2'b00, xd} :
                  t1 && mvi ? (NREG+2)'(1) << TRI_DIN :
                  t3 ? (NREG+2)'(1) << TRI_G : '0;
  assign reg_en = (t1 && (mv || mvi)) || t3 ? xd :
                  t1 && bz_take ? NREG'(1) << (NREG - 1) : '0;
  assign a_en = t1 && ar;
  assign g_en = t2;
  assign alu_sub = t2 && op == OPW'(OP_SUB);
  assign busy = state != IDLE;
  assign done = t3 || (t1 && (mv || mvi || bz || (ill && !TRAP_EN)));
  assign illegal = t1 && ill;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: table-driven, scoreboarded check of bus_sequencer micro-steps.
module tb_bus_sequencer;
  typedef struct packed {
    logic [9:0] tri_en;
    logic [7:0] reg_en;
    logic a_en, g_en, alu_sub, done, illegal;
  } outs_t;
  typedef struct {
    logic [8:0] instr;
    logic zf;
    int n;
    outs_t s1, s2, s3;
  } vec_t;
  logic clk = 0, rst = 1, run = 0, zero_flag = 0;
  logic [8:0] instruction = '0;
  logic [9:0] tri_en;
  logic [7:0] reg_en;
  logic a_en, g_en, alu_sub, busy, done, illegal;
  outs_t cur;
  outs_t exp_q[$];
  vec_t vecs[$];
  int total = 0, bad = 0;
  bus_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instruction(instruction), .zero_flag(zero_flag),
    .tri_en(tri_en), .reg_en(reg_en), .a_en(a_en), .g_en(g_en), .alu_sub(alu_sub),
    .busy(busy), .done(done), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign cur = '{tri_en: tri_en, reg_en: reg_en, a_en: a_en, g_en: g_en,
                 alu_sub: alu_sub, done: done, illegal: illegal};
  function automatic outs_t mk(logic [9:0] t, logic [7:0] r, logic a, logic g, logic s,
                               logic d, logic i);
    return '{tri_en: t, reg_en: r, a_en: a, g_en: g, alu_sub: s, done: d, illegal: i};
  endfunction
  task automatic cmp(string nm, outs_t exp, logic exp_busy);
    total++;
    if (cur !== exp || busy !== exp_busy) begin
      bad++;
      $display("FAIL %s: got tri=%b reg=%b a=%b g=%b sub=%b done=%b ill=%b busy=%b, expected tri=%b reg=%b a=%b g=%b sub=%b done=%b ill=%b busy=%b",
               nm, cur.tri_en, cur.reg_en, cur.a_en, cur.g_en, cur.alu_sub, cur.done, cur.illegal, busy,
               exp.tri_en, exp.reg_en, exp.a_en, exp.g_en, exp.alu_sub, exp.done, exp.illegal, exp_busy);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(logic [8:0] instr, logic zf);
    run = 1;
    instruction = instr;
    zero_flag = zf;
    step();
    run = 0;
    instruction = 9'($urandom);
  endtask
  task automatic drain(string nm, int n);
    outs_t e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s: scoreboard empty at step %0d", nm, k);
      end else begin
        e = exp_q.pop_front();
        cmp($sformatf("%s_t%0d", nm, k + 1), e, 1'b1);
      end
      step();
    end
    cmp($sformatf("%s_idle", nm), '0, 1'b0);
  endtask
  initial begin
    outs_t z;
    z = '0;
    vecs.push_back('{9'b000_010_101, 1'b0, 1, mk(10'b00_0010_0000, 8'b0000_0100, 0, 0, 0, 1, 0), z, z});
    vecs.push_back('{9'b001_011_000, 1'b0, 1, mk(10'b10_0000_0000, 8'b0000_1000, 0, 0, 0, 1, 0), z, z});
    vecs.push_back('{9'b000_111_000, 1'b1, 1, mk(10'b00_0000_0001, 8'b1000_0000, 0, 0, 0, 1, 0), z, z});
    vecs.push_back('{9'b010_000_111, 1'b0, 3, mk(10'b00_0000_0001, 8'b0, 1, 0, 0, 0, 0),
                     mk(10'b00_1000_0000, 8'b0, 0, 1, 0, 0, 0), mk(10'b01_0000_0000, 8'b0000_0001, 0, 0, 0, 1, 0)});
    vecs.push_back('{9'b011_001_100, 1'b0, 3, mk(10'b00_0000_0010, 8'b0, 1, 0, 0, 0, 0),
                     mk(10'b00_0001_0000, 8'b0, 0, 1, 1, 0, 0), mk(10'b01_0000_0000, 8'b0000_0010, 0, 0, 0, 1, 0)});
    vecs.push_back('{9'b100_000_110, 1'b1, 1, mk(10'b00_0100_0000, 8'b1000_0000, 0, 0, 0, 1, 0), z, z});
    vecs.push_back('{9'b100_000_110, 1'b0, 1, mk(10'b0, 8'b0, 0, 0, 0, 1, 0), z, z});
`ifndef BUS_SEQ_ILLEGAL_TRAP_EN
    vecs.push_back('{9'b110_001_010, 1'b0, 1, mk(10'b0, 8'b0, 0, 0, 0, 1, 1), z, z});
`endif
    #2;
    cmp("reset_state", z, 1'b0);
    step();
    rst = 0;
    step();
    cmp("post_reset_idle", z, 1'b0);
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].s1);
      if (vecs[i].n > 1) begin
        exp_q.push_back(vecs[i].s2);
        exp_q.push_back(vecs[i].s3);
      end
      issue(vecs[i].instr, vecs[i].zf);
      drain($sformatf("vec%0d", i), vecs[i].n);
    end
    // run held high across a whole sub; IR changes after acceptance must not matter
    run = 1;
    instruction = 9'b011_001_100;
    step();
    instruction = 9'b000_010_101;
    exp_q.push_back(mk(10'b00_0000_0010, 8'b0, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(10'b00_0001_0000, 8'b0, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(10'b01_0000_0000, 8'b0000_0010, 0, 0, 0, 1, 0));
    drain("held_sub", 3);
    step();
    cmp("held_reaccept_mv", mk(10'b00_0010_0000, 8'b0000_0100, 0, 0, 0, 1, 0), 1'b1);
    run = 0;
    step();
    cmp("held_end_idle", z, 1'b0);
    issue(9'b011_001_100, 1'b0);
    cmp("rstmid_t1", mk(10'b00_0000_0010, 8'b0, 1, 0, 0, 0, 0), 1'b1);
    step();
    cmp("rstmid_t2", mk(10'b00_0001_0000, 8'b0, 0, 1, 1, 0, 0), 1'b1);
    #2 rst = 1;
    #1 cmp("rstmid_async_clear", z, 1'b0);
    #3 rst = 0;
    step();
    cmp("rstmid_still_idle", z, 1'b0);
    exp_q.push_back(mk(10'b00_0010_0000, 8'b0000_0100, 0, 0, 0, 1, 0));
    issue(9'b000_010_101, 1'b0);
    drain("after_rst_mv", 1);
`ifdef BUS_SEQ_ILLEGAL_TRAP_EN
    issue(9'b110_000_000, 1'b0);
    cmp("trap_pulse", mk(10'b0, 8'b0, 0, 0, 0, 0, 1), 1'b1);
    run = 1;
    instruction = 9'b000_010_101;
    for (int k = 0; k < 12; k++) begin
      step();
      cmp($sformatf("trap_hold%0d", k), z, 1'b1);
    end
    run = 0;
    rst = 1;
    #1 cmp("trap_rst", z, 1'b0);
    step();
    rst = 0;
    step();
    cmp("trap_exit_idle", z, 1'b0);
`endif
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
